// File: rtl/sample_frame_buffer.sv
// Ping-pong sample capture buffer feeding the peak detector: frames of FRAME_LEN samples, 2-cycle random-access reads.
// Define SFB_PINGPONG_EN for two banks; left undefined, a single bank is used and capture waits for release.
module sample_frame_buffer #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 420
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic              frame_release,
    output logic              rdy,
    output logic [DATA_W-1:0] dout,
    output logic              ovf,
    output logic [7:0]        ovf_cnt
);

`ifdef SFB_PINGPONG_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif
    localparam int MEM_AW = ADDR_W + BANKS - 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    logic              wr_bank;
    logic              rd_bank;
    logic              wr_bank_next;
    logic              rd_bank_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic [1:0]        full;
    logic              wr_en;
    logic              rel_ok;
    logic              in_range;
    logic [31:0]       addr_ext;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;

    // Read pipeline: stage 1 holds the issued request, stage 2 the RAM output.
    logic [MEM_AW-1:0] rd_idx_q;
    logic              rd_v1;
    logic              rd_ok1;
    logic              rd_v2;
    logic              rd_ok2;
    logic [DATA_W-1:0] ram_q;

`ifdef SFB_PINGPONG_EN
    assign wr_bank_next = ~wr_bank;
    assign rd_bank_next = ~rd_bank;
    assign wr_idx       = {wr_bank, wr_ptr};
    assign rd_idx       = {rd_bank, addr};
`else
    assign wr_bank_next = 1'b0;
    assign rd_bank_next = 1'b0;
    assign wr_idx       = wr_ptr;
    assign rd_idx       = addr;
`endif

    assign wr_en    = s_valid && !full[wr_bank];
    // full[rd_bank] guards against a second pulse while rdy still shows the old bank.
    assign rel_ok   = frame_release && rdy && full[rd_bank];
    assign addr_ext = 32'(addr);
    assign in_range = addr_ext < 32'(FRAME_LEN);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= s_data;
        end
        ram_q <= mem[rd_idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            full    <= 2'b00;
            rdy     <= 1'b0;
            ovf     <= 1'b0;
            ovf_cnt <= 8'd0;
        end else begin
            if (s_valid) begin
                if (!full[wr_bank]) begin
                    if (wr_ptr == LAST) begin
                        full[wr_bank] <= 1'b1;
                        wr_bank       <= wr_bank_next;
                        wr_ptr        <= '0;
                    end else begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                end else begin
                    ovf <= 1'b1;
                    if (ovf_cnt != 8'hFF) begin
                        ovf_cnt <= ovf_cnt + 8'd1;
                    end
                end
            end
            // Completion and release never address the same bank, so both updates stand.
            if (rel_ok) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= rd_bank_next;
            end
            rdy <= full[rd_bank];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx_q <= '0;
            rd_v1    <= 1'b0;
            rd_ok1   <= 1'b0;
            rd_v2    <= 1'b0;
            rd_ok2   <= 1'b0;
            dout     <= '0;
        end else begin
            rd_v1  <= rd;
            rd_ok1 <= rd && rdy && in_range;
            if (rd) begin
                rd_idx_q <= rd_idx;
            end
            rd_v2  <= rd_v1;
            rd_ok2 <= rd_ok1;
            if (rd_v2) begin
                dout <= rd_ok2 ? ram_q : '0;
            end
        end
    end

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Self-checking bench for sample_frame_buffer; follows SFB_PINGPONG_EN to pick the bank-count scenarios.
module tb_sample_frame_buffer;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 420;
`ifdef SFB_PINGPONG_EN
  localparam int BANKS = 2;
`else
  localparam int BANKS = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              rd = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              frame_release = 1'b0;
  logic              rdy;
  logic [DATA_W-1:0] dout;
  logic              ovf;
  logic [7:0]        ovf_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] obs_q[$];
  logic [ADDR_W-1:0] iss_q[$];
  logic [ADDR_W-1:0] plan_addr[$];
  logic [DATA_W-1:0] plan_exp[$];

  sample_frame_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .rd(rd),
    .addr(addr),
    .frame_release(frame_release),
    .rdy(rdy),
    .dout(dout),
    .ovf(ovf),
    .ovf_cnt(ovf_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    rd = 1'b0;
    frame_release = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  task automatic send_samples(input int n, input int base, input int mul);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data = DATA_W'((base + mul * i) % 256);
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
  endtask

  task automatic plan_read(input int a, input int e);
    plan_addr.push_back(ADDR_W'(a));
    plan_exp.push_back(DATA_W'(e));
  endtask

  // Issues planned reads back to back; expected values enter exp_q at issue, dout is captured two edges later.
  task automatic read_burst();
    int n;
    n = plan_addr.size();
    for (int c = 0; c < n + 2; c++) begin
      if (c < n) begin
        rd = 1'b1;
        addr = plan_addr.pop_front();
        iss_q.push_back(addr);
        exp_q.push_back(plan_exp.pop_front());
      end else begin
        rd = 1'b0;
      end
      step();
      if (c >= 2) obs_q.push_back(dout);
    end
    rd = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (10) step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy got=%b want=0", rdy); end
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got=%02h want=00", dout); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    vectors++; if (ovf_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_ovf_cnt got=%0d want=0", ovf_cnt); end
  endtask

  task automatic test_fill();
    logic [DATA_W-1:0] e, o;
    logic [ADDR_W-1:0] a;
    send_samples(FRAME_LEN - 1, 0, 1);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL fill_rdy_early got=%b want=0", rdy); end
    send_samples(1, FRAME_LEN - 1, 1);
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL fill_rdy_at_write got=%b want=0", rdy); end
    step();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL fill_rdy_rise got=%b want=1", rdy); end
    plan_read(419, 8'hA3);
    plan_read(500, 8'h00);
    plan_read(FRAME_LEN, 8'h00);
    plan_read(FRAME_LEN - 1, 8'hA3);
    read_burst();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); a = iss_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL fill_read addr=%0d got=%02h want=%02h", a, o, e); end
    end
    repeat (3) step();
    vectors++; if (dout !== 8'hA3) begin miscompares++; $display("FAIL dout_hold got=%02h want=a3", dout); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e, o;
    logic [ADDR_W-1:0] a;
    int r;
    plan_read(0, 8'h00);
    plan_read(1, 8'h01);
    plan_read(2, 8'h02);
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(FRAME_LEN - 1, 0);
      plan_read(r, r % 256);
    end
    plan_read(4095, 8'h00);
    read_burst();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); a = iss_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_read addr=%0d got=%02h want=%02h", a, o, e); end
    end
  endtask

`ifdef SFB_PINGPONG_EN
  task automatic test_overflow();
    logic [DATA_W-1:0] e, o;
    logic [ADDR_W-1:0] a;
    send_samples(FRAME_LEN + 1, FRAME_LEN, 1);
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got=%b want=1", ovf); end
    vectors++; if (ovf_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_cnt got=%0d want=1", ovf_cnt); end
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL ovf_rdy got=%b want=1", rdy); end
    pulse_release();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL rel_rdy_n1 got=%b want=1", rdy); end
    step();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL rel_rdy_stay got=%b want=1", rdy); end
    plan_read(0, 8'hA4);
    plan_read(419, 8'h47);
    plan_read(1, 8'hA5);
    read_burst();
    pulse_release();
    step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL rel2_rdy_fall got=%b want=0", rdy); end
    plan_read(0, 8'h00);
    read_burst();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); a = iss_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL ovf_read addr=%0d got=%02h want=%02h", a, o, e); end
    end
    vectors++; if (ovf_cnt !== 8'd1) begin miscompares++; $display("FAIL ovf_cnt_keep got=%0d want=1", ovf_cnt); end
  endtask
`else
  task automatic test_single_bank();
    logic [DATA_W-1:0] e, o;
    logic [ADDR_W-1:0] a;
    send_samples(1, 99, 1);
    vectors++; if (ovf_cnt !== 8'd1) begin miscompares++; $display("FAIL single_ovf_cnt got=%0d want=1", ovf_cnt); end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL single_ovf got=%b want=1", ovf); end
    pulse_release();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL single_rel_n1 got=%b want=1", rdy); end
    step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL single_rel_fall got=%b want=0", rdy); end
    send_samples(FRAME_LEN, 50, 1);
    step();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL single_refill_rdy got=%b want=1", rdy); end
    plan_read(0, 8'h32);
    plan_read(419, 8'hD5);
    read_burst();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); a = iss_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL single_read addr=%0d got=%02h want=%02h", a, o, e); end
    end
    vectors++; if (ovf_cnt !== 8'd1) begin miscompares++; $display("FAIL single_cnt_keep got=%0d want=1", ovf_cnt); end
  endtask
`endif

  task automatic test_reset_midfill();
    logic [DATA_W-1:0] e, o;
    logic [ADDR_W-1:0] a;
    do_reset();
    send_samples(200, 11, 1);
    do_reset();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL midfill_rdy got=%b want=0", rdy); end
    vectors++; if (ovf_cnt !== 8'd0) begin miscompares++; $display("FAIL midfill_cnt got=%0d want=0", ovf_cnt); end
    pulse_release();
    repeat (2) step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL idle_release_rdy got=%b want=0", rdy); end
    send_samples(FRAME_LEN - 1, 7, 3);
    step();
    vectors++; if (rdy !== 1'b0) begin miscompares++; $display("FAIL midfill_rdy_419 got=%b want=0", rdy); end
    send_samples(1, 7 + 3 * (FRAME_LEN - 1), 1);
    step();
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL midfill_rdy_420 got=%b want=1", rdy); end
    plan_read(0, 7);
    plan_read(5, 22);
    plan_read(419, (7 + 3 * 419) % 256);
    read_burst();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); a = iss_q.pop_front();
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL midfill_read addr=%0d got=%02h want=%02h", a, o, e); end
    end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL midfill_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_saturate();
    do_reset();
    send_samples(BANKS * FRAME_LEN + 254, 0, 1);
    vectors++; if (ovf_cnt !== 8'd254) begin miscompares++; $display("FAIL sat_cnt_254 got=%0d want=254", ovf_cnt); end
    send_samples(1, 0, 1);
    vectors++; if (ovf_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_cnt_255 got=%0d want=255", ovf_cnt); end
    send_samples(5, 0, 1);
    vectors++; if (ovf_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_cnt_hold got=%0d want=255", ovf_cnt); end
    do_reset();
    vectors++; if (ovf_cnt !== 8'd0 || ovf !== 1'b0) begin miscompares++; $display("FAIL sat_reset got=%0d/%b want=0/0", ovf_cnt, ovf); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
`ifdef SFB_PINGPONG_EN
    test_overflow();
`else
    test_single_bank();
`endif
    test_reset_midfill();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
